// File: rtl/spi_flash_xip_ctrl.sv
// SPI-flash execute-in-place read sequencer.
// Issues one flash READ (0x03) per request through the SPI master's Wishbone registers.
module spi_flash_xip_ctrl #(
    parameter logic [31:0] DIVIDER_VAL = 32'h1,
    parameter logic [7:0]  SS_MASK     = 8'h01,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX1,
        S_TX0,
        S_DIV,
        S_SS,
        S_CTRL,
        S_POLL,
        S_RX0,
        S_SSOFF,
        S_GAP,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    state_e        nxt_q, nxt_d;
    logic [23:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    assign cnt_inc    = cnt_q + 1'b1;
    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign wb_stb_o   = wb_cyc_o;
    assign wb_sel_o   = wb_cyc_o ? 4'hF : 4'h0;

    // State and datapath registers; reset returns everything to idle at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            nxt_q   <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Bus access decode per state, then sequencing on ack/err termination.
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        err_d    = err_q;
        wb_cyc_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = 5'h00;
        wb_dat_o = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    data_d  = 32'h0;
                    state_d = S_TX1;
                end
            end
            S_TX1: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = 5'h04;
                wb_dat_o = {8'h03, addr_q};
            end
            S_TX0: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = 5'h00;
            end
            S_DIV: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = 5'h14;
                wb_dat_o = DIVIDER_VAL;
            end
            S_SS: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = 5'h18;
                wb_dat_o = {24'h0, SS_MASK};
            end
            S_CTRL: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = 5'h10;
                wb_dat_o = 32'h0000_0540;
            end
            S_POLL: begin
                wb_cyc_o = 1'b1;
                wb_adr_o = 5'h10;
            end
            S_RX0: begin
                wb_cyc_o = 1'b1;
                wb_adr_o = 5'h00;
            end
            S_SSOFF: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = 5'h18;
            end
            S_GAP: begin
                state_d = nxt_q;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
            state_d = S_GAP;
            if (wb_err_i) begin
                err_d  = 1'b1;
                data_d = 32'h0;
                if (state_q == S_SSOFF) begin
                    state_d = S_RESP;
                end else begin
                    nxt_d = S_SSOFF;
                end
            end else begin
                case (state_q)
                    S_TX1:  nxt_d = S_TX0;
                    S_TX0:  nxt_d = S_DIV;
                    S_DIV:  nxt_d = S_SS;
                    S_SS:   nxt_d = S_CTRL;
                    S_CTRL: nxt_d = S_POLL;
                    S_POLL: begin
                        if (wb_dat_i[8]) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CW'(TIMEOUT)) begin
                                err_d  = 1'b1;
                                data_d = 32'h0;
                                nxt_d  = S_SSOFF;
                            end else begin
                                nxt_d = S_POLL;
                            end
                        end else begin
                            nxt_d = S_RX0;
                        end
                    end
                    S_RX0: begin
                        data_d = {wb_dat_i[7:0], wb_dat_i[15:8],
                                  wb_dat_i[23:16], wb_dat_i[31:24]};
                        nxt_d  = S_SSOFF;
                    end
                    S_SSOFF: state_d = S_RESP;
                    default: nxt_d = S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_xip_ctrl.sv
// Directed bench for spi_flash_xip_ctrl with a Wishbone SPI-register slave model.
// The DUT is built with TIMEOUT=4 so the poll-timeout path is short.
module tb_spi_flash_xip_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int          busy_left = 0;
    logic [31:0] rx0_val = 32'h0;
    logic        err_en = 1'b0;
    logic [4:0]  err_adr = 5'h0;
    logic [37:0] log_q[$];
    logic [37:0] exp_q[$];

    spi_flash_xip_ctrl #(
        .DIVIDER_VAL(32'h1),
        .SS_MASK    (8'h01),
        .TIMEOUT    (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Slave model: answers one cycle after a strobe is seen, logs each access.
    always @(negedge clock) begin
        if (reset) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
            log_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0});
            wb_dat_i = 32'h0;
            if (!wb_we_o && wb_adr_o == 5'h10) begin
                if (busy_left > 0) begin
                    wb_dat_i  = 32'h0000_0100;
                    busy_left = busy_left - 1;
                end
            end else if (!wb_we_o && wb_adr_o == 5'h00) begin
                wb_dat_i = rx0_val;
            end
            if (err_en && wb_adr_o == err_adr) begin
                wb_err_i = 1'b1;
                err_en   = 1'b0;
            end else begin
                wb_ack_i = 1'b1;
            end
        end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] wr(input logic [4:0] a,
                                       input logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [37:0] rd(input logic [4:0] a);
        return {1'b0, a, 32'h0};
    endfunction

    task automatic exp_setup(input logic [23:0] a);
        exp_q.push_back(wr(5'h04, {8'h03, a}));
        exp_q.push_back(wr(5'h00, 32'h0));
        exp_q.push_back(wr(5'h14, 32'h1));
        exp_q.push_back(wr(5'h18, 32'h1));
        exp_q.push_back(wr(5'h10, 32'h540));
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (resp_valid) break;
            @(negedge clock);
        end
        check({tag, "_resp_to"}, resp_valid, 1'b1);
    endtask

    task automatic issue(input logic [23:0] a);
        for (int i = 0; i < 100; i++) begin
            if (req_ready) break;
            @(negedge clock);
        end
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_data", {resp_err, resp_data}, 33'h0);
        reset = 1'b0;
        @(negedge clock);

        // Single read with three busy polls.
        busy_left = 3;
        rx0_val   = 32'h1122_3344;
        issue(24'h000100);
        wait_resp("t1");
        check("t1_data", resp_data, 32'h4433_2211);
        check("t1_err", resp_err, 1'b0);
        check("t1_sel", wb_sel_o, 4'h0);
        handshake();
        exp_setup(24'h000100);
        repeat (4) exp_q.push_back(rd(5'h10));
        exp_q.push_back(rd(5'h00));
        exp_q.push_back(wr(5'h18, 32'h0));
        cmp_log("t1");

        // Response backpressure.
        busy_left = 0;
        rx0_val   = 32'hAABB_CCDD;
        issue(24'h000200);
        wait_resp("t2");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_v", resp_valid, 1'b1);
            check("t2_hold_d", resp_data, 32'hDDCC_BBAA);
            check("t2_hold_rdy", req_ready, 1'b0);
            @(negedge clock);
        end
        handshake();
        check("t2_post_v", resp_valid, 1'b0);
        check("t2_post_rdy", req_ready, 1'b1);
        log_q.delete();

        // Poll timeout: GO_BSY stuck.
        busy_left = 100;
        issue(24'h000300);
        wait_resp("t3");
        check("t3_err", resp_err, 1'b1);
        check("t3_data", resp_data, 32'h0);
        handshake();
        exp_setup(24'h000300);
        repeat (4) exp_q.push_back(rd(5'h10));
        exp_q.push_back(wr(5'h18, 32'h0));
        cmp_log("t3");
        busy_left = 0;

        // Bus error on the divider write.
        err_en  = 1'b1;
        err_adr = 5'h14;
        rx0_val = 32'h5555_6666;
        issue(24'h000400);
        wait_resp("t4");
        check("t4_err", resp_err, 1'b1);
        check("t4_data", resp_data, 32'h0);
        handshake();
        exp_q.push_back(wr(5'h04, 32'h0300_0400));
        exp_q.push_back(wr(5'h00, 32'h0));
        exp_q.push_back(wr(5'h14, 32'h1));
        exp_q.push_back(wr(5'h18, 32'h0));
        cmp_log("t4");

        // Back-to-back requests with req_valid held high.
        rx0_val   = 32'h0A0B_0C0D;
        req_valid = 1'b1;
        req_addr  = 24'h00A000;
        @(negedge clock);
        req_addr = 24'h00B000;
        wait_resp("t5a");
        check("t5a_data", resp_data, 32'h0D0C_0B0A);
        check("t5a_err", resp_err, 1'b0);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check("t5_idle_rdy", req_ready, 1'b1);
        @(negedge clock);
        req_valid = 1'b0;
        check("t5_next_busy", busy, 1'b1);
        check("t5_next_tx1", {wb_cyc_o, wb_adr_o, wb_dat_o},
              {1'b1, 5'h04, 32'h0300_B000});
        wait_resp("t5b");
        check("t5b_data", resp_data, 32'h0D0C_0B0A);
        handshake();
        for (int k = 0; k < 2; k++) begin
            exp_setup(k == 0 ? 24'h00A000 : 24'h00B000);
            exp_q.push_back(rd(5'h10));
            exp_q.push_back(rd(5'h00));
            exp_q.push_back(wr(5'h18, 32'h0));
        end
        cmp_log("t5");

        // Reset in the middle of polling.
        busy_left = 100;
        issue(24'h000500);
        for (int i = 0; i < 200; i++) begin
            if (wb_cyc_o && !wb_we_o && wb_adr_o == 5'h10) break;
            @(negedge clock);
        end
        check("t6_in_poll", {wb_cyc_o, wb_we_o, wb_adr_o}, {1'b1, 1'b0, 5'h10});
        reset = 1'b1;
        #1;
        check("t6_rst_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
        check("t6_rst_v", resp_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t6_rdy", req_ready, 1'b1);
        log_q.delete();
        busy_left = 2;
        rx0_val   = 32'h0102_0304;
        issue(24'h000600);
        wait_resp("t6");
        check("t6_data", resp_data, 32'h0403_0201);
        check("t6_err", resp_err, 1'b0);
        handshake();
        exp_setup(24'h000600);
        repeat (3) exp_q.push_back(rd(5'h10));
        exp_q.push_back(rd(5'h00));
        exp_q.push_back(wr(5'h18, 32'h0));
        cmp_log("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_xip_ctrl.md
Name: spi_flash_xip_ctrl

Overview:
Wishbone master sequencer that performs one SPI-flash READ (cmd 0x03) per request by programming the SPI master core's register file (TX1, TX0, DIVIDER, SS, CTRL), polling GO_BSY, reading RX0 and releasing SS. It sits between the APB flash-window decoder and the SPI master's Wishbone slave port. It returns a byte-swapped 32-bit word with a valid/ready response handshake.

Parameters:
DIVIDER_VAL, 32'h1, value written to DIVIDER (0x14)
SS_MASK, 8'h01, value written to SS (0x18) to select the flash
TIMEOUT, 1024, maximum number of CTRL polls before the controller aborts with an error

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  read request
req_ready  out  1  controller idle; request accepted when req_valid&&req_ready
req_addr  in  24  flash byte address
resp_valid  out  1  response available; held until resp_ready
resp_ready  in  1  consumer accepts response
resp_data  out  32  read word, little-endian
resp_err  out  1  wb_err_i seen or poll timeout
wb_adr_o  out  5  SPI register address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_sel_o  out  4  byte enables: always 4'hF during an access
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; all wb_* outputs 0; resp_valid=0; resp_data=0; resp_err=0; poll counter=0; address latch=0. req_ready=1 only in IDLE.
- Accept: in IDLE, req_valid=1 latches req_addr and moves to WR_TX1 on the next edge. Requests are ignored while busy.
- Each access state drives cyc=stb=1 with its adr/dat/we. Outputs hold until the cycle in which ack or err is sampled. On that edge cyc/stb drop to 0 for one cycle (GAP) before the next access. Minimum cost is 2 cycles per access plus slave latency.
- Access sequence:
  - WR_TX1: adr 0x04, data {8'h03, addr}.
  - WR_TX0: adr 0x00, data 0.
  - WR_DIV: adr 0x14, data DIVIDER_VAL.
  - WR_SS: adr 0x18, data {24'b0, SS_MASK}.
  - WR_CTRL: adr 0x10, data 32'h0000_0540 (CHAR_LEN=64, GO_BSY bit8=1, Tx_NEG bit10=1, Rx_NEG=0, LSB=0, ASS=0).
  - POLL: read adr 0x10. On ack with wb_dat_i[8]=1, increment the poll counter and repeat POLL after GAP. On ack with bit8=0, go to RD_RX0.
  - RD_RX0: read adr 0x00. Latch resp_data = {d[7:0], d[15:8], d[23:16], d[31:24]}.
  - WR_SSOFF: adr 0x18, data 0.
  - RESP.
- RESP: resp_valid=1, with resp_data and resp_err stable. When resp_ready=1, go to IDLE next edge and clear resp_valid. resp_ready asserted in the same cycle resp_valid rises completes the handshake in that cycle.
- Timeout: if the poll counter reaches TIMEOUT while bit8 is still 1, set resp_err=1 and resp_data=0, skip RD_RX0, and go to WR_SSOFF. SS is always released.
- wb_err_i in any access: treated as termination. Set resp_err=1 and resp_data=0. If the failing access is WR_SSOFF, go to RESP; otherwise go to WR_SSOFF. A second error in WR_SSOFF also goes to RESP.
- If ack and err are both seen in the same cycle, err wins.
- The poll counter clears on request accept. It is wide enough for TIMEOUT (clog2(TIMEOUT+1)).
- resp_err clears on request accept.
- Reset mid-transaction: immediate return to IDLE, outputs at reset values. The SPI core is reset by the same signal, so no SS cleanup is required.

Test Plan:
- Single read, addr 0x000100, slave model acks in 1 cycle, RX0=0x11223344, GO_BSY clears after 3 polls -> access order TX1(0x03000100), TX0(0), DIV(1), SS(1), CTRL(0x540), 4 polls, RX0, SS(0); resp_data=0x44332211, resp_err=0.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable for all 5 cycles; req_ready=0 until 1 cycle after the handshake.
- Timeout with TIMEOUT=4: GO_BSY stuck at 1 -> exactly 4 polls, then SS written 0; resp_err=1, resp_data=0.
- wb_err_i on WR_DIV -> no SS/CTRL/POLL accesses; next access is SS=0; resp_err=1.
- Back-to-back requests with req_valid held continuously -> second request accepted 1 cycle after the first response handshake, with the new address in TX1; no request is dropped or duplicated.
- Assert reset during POLL -> on the same cycle cyc/stb=0, resp_valid=0, busy=0; after release, req_ready=1 and a fresh read completes correctly.
